eei_arbiter: RTL and testbench
==============================

Name: eei_arbiter

Overview:
- Shares one EEI custom execution unit (FGPIO / snapshot-register datapath behind the EEI port) between NUM_REQ requesters, e.g. core pipeline plus debug/DMA agent.
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the winning request's opcode and operands and holds them stable on the downstream EEI port until acknowledged.
- Returns the result to the winner as a one-cycle ack pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 15, cycles to wait for downstream ack before an error completion (1..255).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rq_req_i  in  NUM_REQ  per-requester request level.
- rq_ext_i  in  NUM_REQ  per-requester ext bit.
- rq_funct3_i  in  3*NUM_REQ  funct3, requester k in bits [3k+2:3k].
- rq_funct7_i  in  7*NUM_REQ  funct7, packed the same way.
- rq_rs1_i  in  32*NUM_REQ  rs1 operand, packed.
- rq_rs2_i  in  32*NUM_REQ  rs2 operand, packed.
- rq_ack_o  out  NUM_REQ  one-hot completion pulse.
- rq_error_o  out  1  completion error; valid while any rq_ack_o bit is set.
- rq_rd_val_o  out  32  result; valid while any rq_ack_o bit is set.
- eei_req_o  out  1  downstream request.
- eei_ext_o  out  1  latched ext bit.
- eei_funct3_o  out  3  latched funct3.
- eei_funct7_o  out  7  latched funct7.
- eei_rs1_o  out  32  latched rs1.
- eei_rs2_o  out  32  latched rs2.
- eei_ack_i  in  1  downstream acknowledge.
- eei_error_i  in  1  downstream error; sampled with ack.
- eei_rd_val_i  in  32  downstream result; sampled with ack.
- busy_o  out  1  state is not IDLE.
- grant_o  out  $clog2(NUM_REQ)  index of current or last winner.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, RR pointer=0.
  - All outputs 0, including latched operand registers, grant_o and busy_o.
  - An in-flight transaction is dropped with no ack to any requester.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any rq_req_i bit is set, choose the first set bit searching from the RR pointer upward with wrap-around (pointer=2, NUM_REQ=4, req=4'b0011 -> grant 0).
  - Latch the winner's ext/funct3/funct7/rs1/rs2 and grant_o, clear the timeout counter, go to BUSY.
  - No requests: stay in IDLE.
- BUSY:
  - eei_req_o=1; every eei_* output held constant.
  - eei_ack_i=1: capture eei_error_i and eei_rd_val_i, go to RESP; eei_req_o is 0 in RESP.
  - Otherwise the counter increments; see Optional Feature for timeout.
  - The winner dropping rq_req_i during BUSY is ignored: the transaction completes and is acked.
- RESP:
  - rq_ack_o[grant]=1 for exactly one cycle, with captured rq_error_o and rq_rd_val_o.
  - RR pointer = (grant+1) mod NUM_REQ; go to IDLE.
  - rq_error_o and rq_rd_val_o are 0 outside RESP.
- Latency:
  - Request sampled in cycle 0; eei_req_o high in cycle 1.
  - Downstream ack in cycle 1 -> rq_ack_o in cycle 2.
  - Back-to-back grants start at the earliest in cycle 3 (IDLE in cycle 3).
- Requester protocol:
  - Hold rq_req_i and operands until own ack.
  - Must deassert in the cycle after the ack, or it is a new request.
  - The arbiter samples operands only in IDLE.
- eei_ack_i outside BUSY is ignored.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other transactions.

Optional Feature:
- Macro: EEI_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, if the counter reaches TIMEOUT-1 without ack, go to RESP with rq_error_o=1 and rq_rd_val_o=0; eei_req_o drops.
  - Ack and timeout in the same cycle: ack wins, and downstream error/data are used.
- Undefined: no counter logic; BUSY waits indefinitely for eei_ack_i.

Test Plan:
- Single req: req0 with funct7=7'h01, rs1=32'hA5A5_0000, ack in cycle 1 with rd=32'h1234 -> eei_req_o high in cycle 1, rq_ack_o=2'b01 in cycle 2, rd_val=32'h1234, error=0.
- Contention: req=2'b11 held continuously, immediate acks -> grants alternate 0,1,0,1; each rq_ack_o bit pulses once per transaction.
- Stall: ack delayed 5 cycles; change rq_rs1_i of the winner during BUSY -> eei_rs1_o stays at the originally latched value; rq_ack_o 1 cycle after ack.
- Timeout (EEI_ARB_TIMEOUT_EN, TIMEOUT=15): no ack -> eei_req_o high for exactly 15 cycles, then rq_ack_o with error=1, rd=0; a late eei_ack_i in IDLE is ignored.
- Reset mid-BUSY: assert rst_i asynchronously -> all outputs 0 immediately, no rq_ack_o; after release, req1 alone wins with grant_o=1.
- Wrap-around: NUM_REQ=4, pointer at 3 after a grant to 2, req=4'b0101 -> grant 0.

Source files
------------

// File: rtl/eei_arbiter.sv
// eei_arbiter: shares one EEI custom execution unit between NUM_REQ requesters.
// Round-robin arbitration with a single outstanding transaction. The winner's
// opcode and operands are latched and held on the EEI port until the downstream
// unit acknowledges, and the result goes back to the winner as a one-cycle ack pulse.
// Optional feature: define EEI_ARB_TIMEOUT_EN to complete a transaction with an
// error after TIMEOUT cycles without a downstream ack. Without it, BUSY waits forever.
module eei_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         rq_req_i,
   input  logic [NUM_REQ-1:0]         rq_ext_i,
   input  logic [3*NUM_REQ-1:0]       rq_funct3_i,
   input  logic [7*NUM_REQ-1:0]       rq_funct7_i,
   input  logic [32*NUM_REQ-1:0]      rq_rs1_i,
   input  logic [32*NUM_REQ-1:0]      rq_rs2_i,
   output logic [NUM_REQ-1:0]         rq_ack_o,
   output logic                       rq_error_o,
   output logic [31:0]                rq_rd_val_o,
   output logic                       eei_req_o,
   output logic                       eei_ext_o,
   output logic [2:0]                 eei_funct3_o,
   output logic [6:0]                 eei_funct7_o,
   output logic [31:0]                eei_rs1_o,
   output logic [31:0]                eei_rs2_o,
   input  logic                       eei_ack_i,
   input  logic                       eei_error_i,
   input  logic [31:0]                eei_rd_val_i,
   output logic                       busy_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_o
);

   localparam int GW = $clog2(NUM_REQ);

   // Reject configurations outside the supported range at elaboration time.
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_paramCheck
      $error("eei_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..255");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [GW-1:0]       r_rrPtr;
   logic [GW-1:0]       r_grant;
   logic                r_eeiReq;
   logic                r_eeiExt;
   logic [2:0]          r_eeiFunct3;
   logic [6:0]          r_eeiFunct7;
   logic [31:0]         r_eeiRs1;
   logic [31:0]         r_eeiRs2;
   logic [NUM_REQ-1:0]  r_rqAck;
   logic                r_rqError;
   logic [31:0]         r_rqRdVal;
`ifdef EEI_ARB_TIMEOUT_EN
   logic [7:0]          r_toCnt;
`endif

   logic                w_anyReq;
   logic [GW-1:0]       w_winIdx;
   logic [GW:0]         w_cand;
   logic                w_selExt;
   logic [2:0]          w_selFunct3;
   logic [6:0]          w_selFunct7;
   logic [31:0]         w_selRs1;
   logic [31:0]         w_selRs2;
   logic [NUM_REQ-1:0]  w_grantOneHot;
   logic [GW-1:0]       w_nextPtr;

   // Round-robin search: first requesting index at or above the pointer, wrapping past NUM_REQ-1.
   always_comb begin
      w_anyReq = 1'b0;
      w_winIdx = '0;
      w_cand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand = {1'b0, r_rrPtr} + (GW+1)'(i);
         if (w_cand >= (GW+1)'(NUM_REQ)) begin
            w_cand = w_cand - (GW+1)'(NUM_REQ);
         end
         if (!w_anyReq && rq_req_i[w_cand[GW-1:0]]) begin
            w_anyReq = 1'b1;
            w_winIdx = w_cand[GW-1:0];
         end
      end
   end

   // Pull the winning requester's opcode and operands out of the packed input buses.
   always_comb begin
      w_selExt    = 1'b0;
      w_selFunct3 = '0;
      w_selFunct7 = '0;
      w_selRs1    = '0;
      w_selRs2    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_winIdx == GW'(k)) begin
            w_selExt    = rq_ext_i[k];
            w_selFunct3 = rq_funct3_i[3*k +: 3];
            w_selFunct7 = rq_funct7_i[7*k +: 7];
            w_selRs1    = rq_rs1_i[32*k +: 32];
            w_selRs2    = rq_rs2_i[32*k +: 32];
         end
      end
   end

   // Decode the held grant into the ack vector and the pointer that follows it.
   always_comb begin
      w_grantOneHot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_grantOneHot[k] = (r_grant == GW'(k));
      end
      if (r_grant == GW'(NUM_REQ-1)) begin
         w_nextPtr = '0;
      end else begin
         w_nextPtr = r_grant + 1'b1;
      end
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_rrPtr     <= '0;
         r_grant     <= '0;
         r_eeiReq    <= 1'b0;
         r_eeiExt    <= 1'b0;
         r_eeiFunct3 <= '0;
         r_eeiFunct7 <= '0;
         r_eeiRs1    <= '0;
         r_eeiRs2    <= '0;
         r_rqAck     <= '0;
         r_rqError   <= 1'b0;
         r_rqRdVal   <= '0;
`ifdef EEI_ARB_TIMEOUT_EN
         r_toCnt     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_rqAck   <= '0;
               r_rqError <= 1'b0;
               r_rqRdVal <= '0;
               if (w_anyReq) begin
                  r_grant     <= w_winIdx;
                  r_eeiExt    <= w_selExt;
                  r_eeiFunct3 <= w_selFunct3;
                  r_eeiFunct7 <= w_selFunct7;
                  r_eeiRs1    <= w_selRs1;
                  r_eeiRs2    <= w_selRs2;
                  r_eeiReq    <= 1'b1;
`ifdef EEI_ARB_TIMEOUT_EN
                  r_toCnt     <= '0;
`endif
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (eei_ack_i) begin
                  r_eeiReq  <= 1'b0;
                  r_rqAck   <= w_grantOneHot;
                  r_rqError <= eei_error_i;
                  r_rqRdVal <= eei_rd_val_i;
                  r_state   <= RESP;
               end
`ifdef EEI_ARB_TIMEOUT_EN
               else if (r_toCnt == 8'(TIMEOUT-1)) begin
                  r_eeiReq  <= 1'b0;
                  r_rqAck   <= w_grantOneHot;
                  r_rqError <= 1'b1;
                  r_rqRdVal <= '0;
                  r_state   <= RESP;
               end else begin
                  r_toCnt <= r_toCnt + 8'd1;
               end
`endif
            end
            RESP: begin
               r_rqAck   <= '0;
               r_rqError <= 1'b0;
               r_rqRdVal <= '0;
               r_rrPtr   <= w_nextPtr;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rq_ack_o     = r_rqAck;
   assign rq_error_o   = r_rqError;
   assign rq_rd_val_o  = r_rqRdVal;
   assign eei_req_o    = r_eeiReq;
   assign eei_ext_o    = r_eeiExt;
   assign eei_funct3_o = r_eeiFunct3;
   assign eei_funct7_o = r_eeiFunct7;
   assign eei_rs1_o    = r_eeiRs1;
   assign eei_rs2_o    = r_eeiRs2;
   assign busy_o       = (r_state != IDLE);
   assign grant_o      = r_grant;

endmodule

// File: tb/tb_eei_arbiter.sv
// tb_eei_arbiter: directed and randomized bench for eei_arbiter with four requesters.
// Expected grants come from a round-robin model (pointer plus wrap-around search)
// and expected operands/results from the values the bench itself drove.
module tb_eei_arbiter;

   localparam int NREQ = 4;
   localparam int TMO  = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   rq_req_i;
   logic [NREQ-1:0]   rq_ext_i;
   logic [3*NREQ-1:0] rq_funct3_i;
   logic [7*NREQ-1:0] rq_funct7_i;
   logic [32*NREQ-1:0] rq_rs1_i;
   logic [32*NREQ-1:0] rq_rs2_i;
   logic [NREQ-1:0]   rq_ack_o;
   logic              rq_error_o;
   logic [31:0]       rq_rd_val_o;
   logic              eei_req_o;
   logic              eei_ext_o;
   logic [2:0]        eei_funct3_o;
   logic [6:0]        eei_funct7_o;
   logic [31:0]       eei_rs1_o;
   logic [31:0]       eei_rs2_o;
   logic              eei_ack_i;
   logic              eei_error_i;
   logic [31:0]       eei_rd_val_i;
   logic              busy_o;
   logic [1:0]        grant_o;

   eei_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .rq_req_i(rq_req_i), .rq_ext_i(rq_ext_i),
      .rq_funct3_i(rq_funct3_i), .rq_funct7_i(rq_funct7_i),
      .rq_rs1_i(rq_rs1_i), .rq_rs2_i(rq_rs2_i),
      .rq_ack_o(rq_ack_o), .rq_error_o(rq_error_o), .rq_rd_val_o(rq_rd_val_o),
      .eei_req_o(eei_req_o), .eei_ext_o(eei_ext_o),
      .eei_funct3_o(eei_funct3_o), .eei_funct7_o(eei_funct7_o),
      .eei_rs1_o(eei_rs1_o), .eei_rs2_o(eei_rs2_o),
      .eei_ack_i(eei_ack_i), .eei_error_i(eei_error_i), .eei_rd_val_i(eei_rd_val_i),
      .busy_o(busy_o), .grant_o(grant_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int              checks = 0;
   int              errors = 0;
   int              modelPtr;
   logic [NREQ-1:0] pend;
   logic            opExt  [NREQ];
   logic [2:0]      opF3   [NREQ];
   logic [6:0]      opF7   [NREQ];
   logic [31:0]     opRs1  [NREQ];
   logic [31:0]     opRs2  [NREQ];

   // One comparison point: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive the pending-request mask and every requester's operands onto the DUT.
   task automatic applyStimulus();
      for (int k = 0; k < NREQ; k++) begin
         rq_ext_i[k]            = opExt[k];
         rq_funct3_i[3*k +: 3]  = opF3[k];
         rq_funct7_i[7*k +: 7]  = opF7[k];
         rq_rs1_i[32*k +: 32]   = opRs1[k];
         rq_rs2_i[32*k +: 32]   = opRs2[k];
      end
      rq_req_i = pend;
   endtask

   task automatic randomOps(input int k);
      opExt[k] = 1'($urandom_range(0, 1));
      opF3[k]  = 3'($urandom_range(0, 7));
      opF7[k]  = 7'($urandom_range(0, 127));
      opRs1[k] = $urandom;
      opRs2[k] = $urandom;
   endtask

   // Round-robin reference: first set bit at or after ptr, modulo NREQ.
   function automatic int modelPick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".ack"},    32'(rq_ack_o),    32'h0);
      checkOutput({tag, ".err"},    32'(rq_error_o),  32'h0);
      checkOutput({tag, ".rd"},     rq_rd_val_o,      32'h0);
      checkOutput({tag, ".eeiReq"}, 32'(eei_req_o),   32'h0);
      checkOutput({tag, ".ext"},    32'(eei_ext_o),   32'h0);
      checkOutput({tag, ".f3"},     32'(eei_funct3_o), 32'h0);
      checkOutput({tag, ".f7"},     32'(eei_funct7_o), 32'h0);
      checkOutput({tag, ".rs1"},    eei_rs1_o,        32'h0);
      checkOutput({tag, ".rs2"},    eei_rs2_o,        32'h0);
      checkOutput({tag, ".busy"},   32'(busy_o),      32'h0);
      checkOutput({tag, ".grant"},  32'(grant_o),     32'h0);
   endtask

   // One transaction from an IDLE negedge with requests already applied, back to the next IDLE negedge.
   task automatic runTxn(input string tag, input int expWin, input int delay,
                         input logic [31:0] rd, input logic err, input bit keep, input bit stall);
      checkOutput({tag, ".idleBusy"}, 32'(busy_o), 32'h0);
      checkOutput({tag, ".idleAck"},  32'(rq_ack_o), 32'h0);
      @(negedge clk);
      checkOutput({tag, ".eeiReq"}, 32'(eei_req_o), 32'h1);
      checkOutput({tag, ".busy"},   32'(busy_o), 32'h1);
      checkOutput({tag, ".grant"},  32'(grant_o), 32'(expWin));
      checkOutput({tag, ".ext"},    32'(eei_ext_o), 32'(opExt[expWin]));
      checkOutput({tag, ".f3"},     32'(eei_funct3_o), 32'(opF3[expWin]));
      checkOutput({tag, ".f7"},     32'(eei_funct7_o), 32'(opF7[expWin]));
      checkOutput({tag, ".rs1"},    eei_rs1_o, opRs1[expWin]);
      checkOutput({tag, ".rs2"},    eei_rs2_o, opRs2[expWin]);
      if (stall) rq_rs1_i[32*expWin +: 32] = ~opRs1[expWin];
      for (int c = 0; c < delay; c++) begin
         @(negedge clk);
         checkOutput({tag, ".stallReq"}, 32'(eei_req_o), 32'h1);
         checkOutput({tag, ".stallAck"}, 32'(rq_ack_o), 32'h0);
         if (stall) checkOutput({tag, ".stallRs1"}, eei_rs1_o, opRs1[expWin]);
      end
      eei_ack_i    = 1'b1;
      eei_rd_val_i = rd;
      eei_error_i  = err;
      @(negedge clk);
      eei_ack_i    = 1'b0;
      eei_rd_val_i = $urandom;
      eei_error_i  = 1'b0;
      checkOutput({tag, ".ack"},    32'(rq_ack_o), 32'(1 << expWin));
      checkOutput({tag, ".rd"},     rq_rd_val_o, rd);
      checkOutput({tag, ".err"},    32'(rq_error_o), 32'(err));
      checkOutput({tag, ".respReq"}, 32'(eei_req_o), 32'h0);
      if (!keep) pend[expWin] = 1'b0;
      applyStimulus();
      modelPtr = (expWin + 1) % NREQ;
      @(negedge clk);
      checkOutput({tag, ".afterAck"}, 32'(rq_ack_o), 32'h0);
      checkOutput({tag, ".afterRd"},  rq_rd_val_o, 32'h0);
      checkOutput({tag, ".afterErr"}, 32'(rq_error_o), 32'h0);
   endtask

   initial begin
      int expSeq [4];
      int toCycles;
      int win;
      rst = 1'b1;
      eei_ack_i = 1'b0;
      eei_error_i = 1'b0;
      eei_rd_val_i = '0;
      pend = '0;
      modelPtr = 0;
      for (int k = 0; k < NREQ; k++) begin
         opExt[k] = 1'b0; opF3[k] = '0; opF7[k] = '0; opRs1[k] = '0; opRs2[k] = '0;
      end
      applyStimulus();
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single request");
      opExt[0] = 1'b1; opF3[0] = 3'b010; opF7[0] = 7'h01;
      opRs1[0] = 32'hA5A5_0000; opRs2[0] = 32'h0000_0042;
      pend = 4'b0001;
      applyStimulus();
      runTxn("single", 0, 0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

      $display("[TB] contention");
      randomOps(0); randomOps(1);
      pend = 4'b0011;
      applyStimulus();
      expSeq = '{1, 0, 1, 0};
      for (int t = 0; t < 4; t++) begin
         runTxn("contend", expSeq[t], 0, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      pend = '0;
      applyStimulus();

      $display("[TB] stall with operand change");
      randomOps(2);
      pend = 4'b0100;
      applyStimulus();
      runTxn("stall", 2, 5, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);

      $display("[TB] wrap-around");
      randomOps(0); randomOps(2);
      pend = 4'b0101;
      applyStimulus();
      runTxn("wrap", 0, 1, 32'h0BAD_0001, 1'b0, 1'b0, 1'b0);
      runTxn("wrap2", 2, 0, 32'h0BAD_0002, 1'b0, 1'b0, 1'b0);

      $display("[TB] ack while idle");
      eei_ack_i = 1'b1; eei_error_i = 1'b1; eei_rd_val_i = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      checkOutput("idleAck.busy", 32'(busy_o), 32'h0);
      checkOutput("idleAck.ack",  32'(rq_ack_o), 32'h0);
      checkOutput("idleAck.rd",   rq_rd_val_o, 32'h0);
      eei_ack_i = 1'b0; eei_error_i = 1'b0;

      randomOps(3);
      pend = 4'b1000;
      applyStimulus();
`ifdef EEI_ARB_TIMEOUT_EN
      $display("[TB] ack on the timeout cycle");
      runTxn("tie", 3, TMO - 1, 32'h0000_0055, 1'b0, 1'b0, 1'b0);

      $display("[TB] timeout");
      randomOps(1);
      pend = 4'b0010;
      applyStimulus();
      eei_rd_val_i = 32'hDEAD_BEEF;
      @(negedge clk);
      toCycles = 0;
      while (eei_req_o === 1'b1 && toCycles < 40) begin
         toCycles++;
         @(negedge clk);
      end
      checkOutput("timeout.reqCycles", 32'(toCycles), 32'(TMO));
      checkOutput("timeout.ack", 32'(rq_ack_o), 32'h2);
      checkOutput("timeout.err", 32'(rq_error_o), 32'h1);
      checkOutput("timeout.rd",  rq_rd_val_o, 32'h0);
      pend = '0;
      applyStimulus();
      modelPtr = 2;
      @(negedge clk);
      eei_ack_i = 1'b1;
      @(negedge clk);
      eei_ack_i = 1'b0;
      checkOutput("lateAck.busy", 32'(busy_o), 32'h0);
      checkOutput("lateAck.ack",  32'(rq_ack_o), 32'h0);
`else
      $display("[TB] long stall without timeout");
      runTxn("noTimeout", 3, TMO + 5, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
`endif

      $display("[TB] reset during BUSY");
      randomOps(0);
      pend = 4'b0001;
      applyStimulus();
      @(negedge clk);
      checkOutput("rstMid.busyBefore", 32'(busy_o), 32'h1);
      #2 rst = 1'b1;
      #1 checkAllZero("rstMid");
      pend = 4'b0010;
      randomOps(1);
      applyStimulus();
      @(negedge clk);
      checkOutput("rstMid.heldAck", 32'(rq_ack_o), 32'h0);
      rst = 1'b0;
      modelPtr = 0;
      runTxn("afterRst", 1, 0, 32'h0000_2222, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
               pend[k] = 1'b1;
               randomOps(k);
            end
         end
         if (pend == '0) begin
            win = int'($urandom_range(0, NREQ - 1));
            pend[win] = 1'b1;
            randomOps(win);
         end
         applyStimulus();
         win = modelPick(pend, modelPtr);
         runTxn("rand", win, int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)),
                1'b0, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
